// File: rtl/count_sequencer.sv
// Run controller for the auto-incrementing count datapath: button conditioning,
// 1 Hz tick generation and the IDLE/RUN/PAUSE/DONE sequencing of the external counter.
module count_sequencer #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TARGET          = 150,
  parameter int HOLD_TICKS      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic [7:0] count_value,
  output logic       cnt_clear,
  output logic       cnt_inc,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);
  localparam logic [7:0]    TARGET_V  = 8'(TARGET);

  // Button path, bit 0 = start, bit 1 = stop.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    level_q, level_d;
  logic [1:0]    level_dly_q;
  logic [1:0]    ev_q, ev_d;
  logic [DW-1:0] deb_q [2];
  logic [DW-1:0] deb_d [2];

  logic          start_ev, stop_ev;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          clear_q, clear_d;
  logic          inc_q, inc_d;
  logic          active, tick;

  // Debounce counter runs while the synchronized level disagrees with the
  // accepted level; any return to agreement restarts it.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_q[i] == DEB_MAX) begin
          level_d[i] = sync2_q[i];
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
    end
    ev_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      ev_q        <= '0;
      for (int i = 0; i < 2; i++) deb_q[i] <= '0;
    end else begin
      sync1_q     <= {stop_btn, start_btn};
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      ev_q        <= ev_d;
      for (int i = 0; i < 2; i++) deb_q[i] <= deb_d[i];
    end
  end

  assign start_ev = ev_q[0];
  assign stop_ev  = ev_q[1];

  // Strobes to the datapath are fire-and-forget: registered, one cycle wide,
  // never simultaneous, and the counter must act on every one it sees.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    clear_d = 1'b0;
    inc_d   = 1'b0;
    active  = (state_q == ST_RUN) || (state_q == ST_DONE);
    tick    = active && (presc_q == PRESC_MAX);

    // PAUSE leaves the prescaler untouched so a resume finishes the partial period.
    if (active) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end else if (state_q == ST_IDLE) begin
      presc_d = '0;
    end

    if (stop_ev) begin
      state_d = ST_IDLE;
      clear_d = 1'b1;
    end else if (start_ev) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_RUN;
          clear_d = 1'b1;
          presc_d = '0;
        end
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (tick) begin
      if (state_q == ST_RUN) begin
        if (count_value == TARGET_V) begin
          state_d = ST_DONE;
          hold_d  = '0;
        end else begin
          inc_d = 1'b1;
        end
      end else if (state_q == ST_DONE) begin
        if (hold_q == HOLD_MAX) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      clear_q <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      clear_q <= clear_d;
      inc_q   <= inc_d;
    end
  end

  assign cnt_clear = clear_q;
  assign cnt_inc   = inc_q;
  assign done      = (state_q == ST_DONE);
  assign state     = state_q;

endmodule
